pulse_measure: RTL

//  Receive-side counterpart of the pulse stimulus generators: measures a free-running

---
 rtl/pulse_measure.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pulse_measure.sv
// Measures high width and rising-to-rising period of an asynchronous pulse train in clk cycles.
// Optional deglitch filter between synchronizer and edge detect: define PULSE_MEASURE_FILTER_EN.
module pulse_measure #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH      = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             overflow,
  output logic             idle
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pulse_measure: SYNC_STAGES must be >= 2");
  end
  if (GLITCH < 1) begin : g_bad_glitch
    $error("pulse_measure: GLITCH must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, lvl, prev_q, rise, fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef PULSE_MEASURE_FILTER_EN
  localparam int GW = $clog2(GLITCH + 1);

  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          f_q, f_d;

  // f follows s only after GLITCH consecutive cycles of disagreement
  always_comb begin
    gcnt_d = '0;
    f_d    = f_q;
    if (s != f_q) begin
      if (gcnt_q == GW'(GLITCH - 1)) f_d    = s;
      else                           gcnt_d = gcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gcnt_q <= '0;
      f_q    <= 1'b0;
    end else begin
      gcnt_q <= gcnt_d;
      f_q    <= f_d;
    end
  end

  assign lvl = f_q;
`else
  assign lvl = s;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_q <= 1'b0;
    else          prev_q <= lvl;
  end

  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_hi_q, cnt_hi_d, cnt_per_q, cnt_per_d, hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] width_q, width_d, period_q, period_d;
  logic             valid_q, valid_d, overflow_q, overflow_d;

  always_comb begin
    state_d    = state_q;
    cnt_hi_d   = cnt_hi_q;
    cnt_per_d  = cnt_per_q;
    hi_lat_d   = hi_lat_q;
    width_d    = width_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    overflow_d = 1'b0;
    if (!enable) begin
      state_d   = IDLE;
      cnt_hi_d  = '0;
      cnt_per_d = '0;
      hi_lat_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d   = HIGH;
            cnt_hi_d  = CNT_ONE;
            cnt_per_d = CNT_ONE;
          end
        end
        HIGH: begin
          // cnt_hi never exceeds cnt_per, so only the period counter is watched
          if (cnt_per_q == CNT_MAX) begin
            overflow_d = 1'b1;
            state_d    = IDLE;
            cnt_hi_d   = '0;
            cnt_per_d  = '0;
            hi_lat_d   = '0;
          end else if (fall) begin
            hi_lat_d  = cnt_hi_q;
            cnt_per_d = cnt_per_q + 1'b1;
            state_d   = LOW;
          end else begin
            cnt_hi_d  = cnt_hi_q + 1'b1;
            cnt_per_d = cnt_per_q + 1'b1;
          end
        end
        LOW: begin
          // a rise on the saturating cycle still completes the period
          if (rise) begin
            width_d   = hi_lat_q;
            period_d  = cnt_per_q;
            valid_d   = 1'b1;
            cnt_hi_d  = CNT_ONE;
            cnt_per_d = CNT_ONE;
            state_d   = HIGH;
          end else if (cnt_per_q == CNT_MAX) begin
            overflow_d = 1'b1;
            state_d    = IDLE;
            cnt_hi_d   = '0;
            cnt_per_d  = '0;
            hi_lat_d   = '0;
          end else begin
            cnt_per_d = cnt_per_q + 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          cnt_hi_d  = '0;
          cnt_per_d = '0;
          hi_lat_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_hi_q   <= '0;
      cnt_per_q  <= '0;
      hi_lat_q   <= '0;
      width_q    <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_hi_q   <= cnt_hi_d;
      cnt_per_q  <= cnt_per_d;
      hi_lat_q   <= hi_lat_d;
      width_q    <= width_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign width    = width_q;
  assign period   = period_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
  assign idle     = (state_q == IDLE);

endmodule
